vga_timing: RTL

Generates the 640x480@60 Hz raster for the Pokémon display path. It sits directly upstream of the sprite renderers (squirtle and its siblings) and drives their `x`/`y` pixel-coordinate inputs from free-running horizontal and vertical counters. It emits VGA sync and blank strobes delayed so that they line up with the renderers' one-cycle registered `r`/`g`/`b`. It also emits a per-frame pulse that the sprite-position logic uses to update `x0`/`y0` safely.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_sync_delay.sv | 35 +++
 rtl/vga_timing.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the sync strobe bundle for the VGA raster path.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic blank_n;
    } sync_t;

    // Idle strobe levels: syncs deasserted, picture blanked.
    localparam sync_t SYNC_RST = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_timing_sync_delay.sv
// N-stage register chain that aligns hsync_n/vsync_n/blank_n with the renderer colour register.
module sync_delay
    import vga_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);

    if (N == 0) begin : g_pass
        assign q_o = d_i;
    end else begin : g_chain
        logic [2:0] stage_q [N];

        // Shift every clk so the delay is measured in clk, not pixels.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(N); i++) begin
                    stage_q[i] <= SYNC_RST;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(N); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[N-1];
    end

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: pixel divider, h/v counters, delayed sync/blank and a frame pulse.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP       = vga_pkg::H_FP,
    parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
    parameter int unsigned H_BP       = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP       = vga_pkg::V_FP,
    parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
    parameter int unsigned V_BP       = vga_pkg::V_BP,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank_n,
    output logic       frame_start
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             frame_start_q, frame_start_d;

    logic  div_last_c;
    logic  tick_c;
    logic  h_wrap_c;
    logic  v_wrap_c;
    logic  active_c;
    sync_t raw_c;
    sync_t dly_c;

    // Gating with rst keeps pix_tick low in reset even when CLK_DIV=1 pins the divider.
    assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));
    assign tick_c     = rst && div_last_c;
    assign h_wrap_c   = (hcnt_q == CNT_W'(H_TOT - 1));
    assign v_wrap_c   = (vcnt_q == CNT_W'(V_TOT - 1));
    assign active_c   = (hcnt_q < CNT_W'(H_ACTIVE)) && (vcnt_q < CNT_W'(V_ACTIVE));

    always_comb begin
        div_d         = div_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        frame_start_d = 1'b0;

        if (div_last_c) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (tick_c) begin
            if (h_wrap_c) begin
                hcnt_d        = '0;
                vcnt_d        = v_wrap_c ? '0 : vcnt_q + CNT_W'(1);
                frame_start_d = (vcnt_q == CNT_W'(V_ACTIVE - 1));
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Raw strobes straight from the counters; blank is forced during reset for the zero-delay build.
    always_comb begin
        raw_c         = SYNC_RST;
        raw_c.hsync_n = !((hcnt_q >= CNT_W'(HS_START)) && (hcnt_q < CNT_W'(HS_END)));
        raw_c.vsync_n = !((vcnt_q >= CNT_W'(VS_START)) && (vcnt_q < CNT_W'(VS_END)));
        raw_c.blank_n = active_c && rst;
    end

    sync_delay #(
        .N (PIPE_DELAY)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (raw_c),
        .q_o   (dly_c)
    );

    assign pix_tick    = tick_c;
    assign x           = active_c ? X_W'(hcnt_q) : '0;
    assign y           = active_c ? Y_W'(vcnt_q) : '0;
    assign hsync_n     = dly_c.hsync_n;
    assign vsync_n     = dly_c.vsync_n;
    assign blank_n     = dly_c.blank_n;
    assign frame_start = frame_start_q;

endmodule
